// File: rtl/freq_meter_ctrl.sv
// Gated frequency meter: counts synchronized rising edges of SIG_i over a
// programmable window of CLK_IN cycles and publishes the saturating count.
module freq_meter_ctrl #(
   parameter int GATE_W = 24,
   parameter int CNT_W  = 16
) (
   input  logic              CLK_IN,
   input  logic              RST_IN,
   input  logic              SIG_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              mode_i,
   input  logic [GATE_W-1:0] gate_len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              overflow_o,
   output logic [7:0]        led_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      GATE  = 2'd2,
      LATCH = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic sync1;
   logic sync2;
   logic last;
   logic edge_det;

   logic [GATE_W-1:0] gate_q;
   logic              mode_q;
   logic [GATE_W-1:0] timer;
   logic [CNT_W-1:0]  work_cnt;
   logic              sat;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              sat_nxt;
   logic              accept;

   // Two-flop synchronizer plus history flop for rising-edge detection
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         last  <= 1'b0;
      end else begin
         sync1 <= SIG_i;
         sync2 <= sync1;
         last  <= sync2;
      end
   end

   assign edge_det = sync2 & ~last;

   // State register
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort wins over start and over continuous re-arm
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (!abort_i && start_i && (gate_len_i != '0)) begin
               state_nxt = ARM;
            end
         end
         ARM: begin
            state_nxt = abort_i ? IDLE : GATE;
         end
         GATE: begin
            if (abort_i) begin
               state_nxt = IDLE;
            end else if (timer == GATE_W'(1)) begin
               state_nxt = LATCH;
            end
         end
         LATCH: begin
            state_nxt = (abort_i || !mode_q) ? IDLE : ARM;
         end
      endcase
   end

   assign accept = (state == IDLE) && (state_nxt == ARM);

   // Saturating increment of the working counter with sticky overflow
   always_comb begin
      cnt_nxt = work_cnt;
      sat_nxt = sat;
      if (edge_det && (state == GATE)) begin
         if (work_cnt == '1) begin
            sat_nxt = 1'b1;
         end else begin
            cnt_nxt = work_cnt + 1'b1;
         end
      end
   end

   // Measurement datapath: latch settings, run timer, count, publish
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         gate_q     <= '0;
         mode_q     <= 1'b0;
         timer      <= '0;
         work_cnt   <= '0;
         sat        <= 1'b0;
         count_o    <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (accept) begin
            gate_q <= gate_len_i;
            mode_q <= mode_i;
         end
         if (state == ARM) begin
            work_cnt <= '0;
            sat      <= 1'b0;
            timer    <= gate_q;
         end
         if (state == GATE) begin
            timer    <= timer - 1'b1;
            work_cnt <= cnt_nxt;
            sat      <= sat_nxt;
            if (state_nxt == LATCH) begin
               count_o    <= cnt_nxt;
               overflow_o <= sat_nxt;
            end
         end
      end
   end

   assign busy_o = (state != IDLE);
   assign done_o = (state == LATCH);

   // Narrow counters drive the low LEDs and leave the rest dark
   generate
      if (CNT_W >= 8) begin : g_led_wide
         assign led_o = count_o[7:0];
      end else begin : g_led_narrow
         assign led_o = {{(8-CNT_W){1'b0}}, count_o};
      end
   endgenerate

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Directed bench for freq_meter_ctrl: default instance plus a 4-bit
// counter instance sharing all inputs for saturation scenarios.
module tb_freq_meter_ctrl;

   logic        CLK_IN = 1'b0;
   logic        RST_IN;
   logic        SIG_i;
   logic        start_i;
   logic        abort_i;
   logic        mode_i;
   logic [23:0] gate_len_i;

   logic        busy_o;
   logic        done_o;
   logic [15:0] count_o;
   logic        overflow_o;
   logic [7:0]  led_o;

   logic        busy4;
   logic        done4;
   logic [3:0]  count4;
   logic        ov4;
   logic [7:0]  led4;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int t_acc      = 0;

   int   sig_per = 0;
   int   ph      = 0;
   logic wave    = 1'b0;
   logic sig_man = 1'b0;

   freq_meter_ctrl dut (
      .CLK_IN     (CLK_IN),
      .RST_IN     (RST_IN),
      .SIG_i      (SIG_i),
      .start_i    (start_i),
      .abort_i    (abort_i),
      .mode_i     (mode_i),
      .gate_len_i (gate_len_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .count_o    (count_o),
      .overflow_o (overflow_o),
      .led_o      (led_o)
   );

   freq_meter_ctrl #(.CNT_W(4)) dut4 (
      .CLK_IN     (CLK_IN),
      .RST_IN     (RST_IN),
      .SIG_i      (SIG_i),
      .start_i    (start_i),
      .abort_i    (abort_i),
      .mode_i     (mode_i),
      .gate_len_i (gate_len_i),
      .busy_o     (busy4),
      .done_o     (done4),
      .count_o    (count4),
      .overflow_o (ov4),
      .led_o      (led4)
   );

   always #5 CLK_IN = ~CLK_IN;

   always @(posedge CLK_IN) cyc <= cyc + 1;

   // Periodic square wave, high for the first half of each period
   always @(negedge CLK_IN) begin
      if (sig_per > 0) begin
         ph   = (ph + 1 >= sig_per) ? 0 : ph + 1;
         wave = (ph < sig_per / 2);
      end
   end

   assign SIG_i = (sig_per > 0) ? wave : sig_man;

   // Pulse start for one edge; t_acc = cycle index of the accepting edge
   task automatic start_meas(input int n, input logic m);
      @(negedge CLK_IN);
      gate_len_i = 24'(n);
      mode_i     = m;
      start_i    = 1'b1;
      @(negedge CLK_IN);
      start_i = 1'b0;
      t_acc   = cyc;
   endtask

   // Wait for the next done pulse; at = cycle index, or -1 on timeout
   task automatic wait_done(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge CLK_IN);
         if (done_o) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int nbusy;
      RST_IN     = 1'b1;
      start_i    = 1'b0;
      abort_i    = 1'b0;
      mode_i     = 1'b0;
      gate_len_i = '0;
      sig_per    = 0;
      sig_man    = 1'b1;
      repeat (3) @(negedge CLK_IN);
      compared++;
      if ({busy_o, done_o, count_o, overflow_o, led_o} !== 27'd0) begin
         mismatched++;
         $display("FAIL reset_out: got busy=%b done=%b cnt=%0d ov=%b led=%h, need all 0",
                  busy_o, done_o, count_o, overflow_o, led_o);
      end
      compared++;
      if ({busy4, done4, count4, ov4, led4} !== 15'd0) begin
         mismatched++;
         $display("FAIL reset_out4: got busy=%b done=%b cnt=%0d ov=%b, need all 0",
                  busy4, done4, count4, ov4);
      end
      RST_IN = 1'b0;
      nbusy  = 0;
      repeat (10) begin
         @(negedge CLK_IN);
         if (busy_o || done_o) nbusy++;
      end
      compared++;
      if (nbusy !== 0 || count_o !== 16'd0) begin
         mismatched++;
         $display("FAIL reset_release: got busy/done cycles=%0d cnt=%0d, need 0 and 0",
                  nbusy, count_o);
      end
      sig_man = 1'b0;
   endtask

   task automatic test_single_shot();
      int nbusy;
      int ndone;
      int dt;
      sig_per = 10;
      repeat (20) @(negedge CLK_IN);
      start_meas(100, 1'b0);
      nbusy = 0;
      ndone = 0;
      dt    = -1;
      for (int i = 0; i < 120; i++) begin
         if (busy_o) nbusy++;
         if (done_o) begin
            ndone++;
            dt = cyc - t_acc;
         end
         @(negedge CLK_IN);
      end
      compared++;
      if (nbusy !== 102) begin
         mismatched++;
         $display("FAIL single_busy: got %0d busy cycles, need 102", nbusy);
      end
      compared++;
      if (ndone !== 1 || dt !== 101) begin
         mismatched++;
         $display("FAIL single_done: got %0d pulses at +%0d, need 1 at +101",
                  ndone, dt);
      end
      compared++;
      if (count_o !== 16'd10 || overflow_o !== 1'b0 || led_o !== 8'd10) begin
         mismatched++;
         $display("FAIL single_count: got cnt=%0d ov=%b led=%0d, need 10 0 10",
                  count_o, overflow_o, led_o);
      end
   endtask

   task automatic test_saturation();
      int at;
      sig_per = 4;
      repeat (8) @(negedge CLK_IN);
      start_meas(200, 1'b0);
      wait_done(300, at);
      compared++;
      if (at - t_acc !== 201) begin
         mismatched++;
         $display("FAIL sat_latency: got done at +%0d, need +201", at - t_acc);
      end
      compared++;
      if (count4 !== 4'd15 || ov4 !== 1'b1 || led4 !== 8'd15) begin
         mismatched++;
         $display("FAIL sat_cnt4: got cnt=%0d ov=%b led=%0d, need 15 1 15",
                  count4, ov4, led4);
      end
      compared++;
      if (count_o !== 16'd50 || overflow_o !== 1'b0) begin
         mismatched++;
         $display("FAIL sat_cnt16: got cnt=%0d ov=%b, need 50 0",
                  count_o, overflow_o);
      end
      start_meas(20, 1'b0);
      wait_done(60, at);
      compared++;
      if (at < 0 || count4 !== 4'd5 || ov4 !== 1'b0 || count_o !== 16'd5) begin
         mismatched++;
         $display("FAIL sat_clear: got at=%0d cnt4=%0d ov4=%b cnt=%0d, need 5 0 5",
                  at, count4, ov4, count_o);
      end
   endtask

   task automatic test_continuous();
      int c1;
      int c2;
      int c3;
      sig_per = 5;
      repeat (10) @(negedge CLK_IN);
      start_meas(50, 1'b1);
      wait_done(100, c1);
      compared++;
      if (c1 - t_acc !== 51 || count_o !== 16'd10) begin
         mismatched++;
         $display("FAIL cont_first: got +%0d cnt=%0d, need +51 cnt=10",
                  c1 - t_acc, count_o);
      end
      gate_len_i = 24'd7;
      mode_i     = 1'b0;
      wait_done(100, c2);
      compared++;
      if (c2 - c1 !== 52 || count_o !== 16'd10) begin
         mismatched++;
         $display("FAIL cont_period2: got %0d cnt=%0d, need 52 cnt=10",
                  c2 - c1, count_o);
      end
      wait_done(100, c3);
      compared++;
      if (c3 - c2 !== 52 || count_o !== 16'd10) begin
         mismatched++;
         $display("FAIL cont_period3: got %0d cnt=%0d, need 52 cnt=10",
                  c3 - c2, count_o);
      end
      repeat (10) @(negedge CLK_IN);
      abort_i = 1'b1;
      @(negedge CLK_IN);
      abort_i = 1'b0;
      compared++;
      if (busy_o !== 1'b0) begin
         mismatched++;
         $display("FAIL cont_abort: got busy=%b, need 0", busy_o);
      end
   endtask

   task automatic test_abort();
      int nbusy;
      int ndone;
      sig_per = 10;
      start_meas(100, 1'b0);
      repeat (30) @(negedge CLK_IN);
      abort_i = 1'b1;
      @(negedge CLK_IN);
      abort_i = 1'b0;
      compared++;
      if (busy_o !== 1'b0) begin
         mismatched++;
         $display("FAIL abort_idle: got busy=%b, need 0", busy_o);
      end
      nbusy = 0;
      ndone = 0;
      repeat (120) begin
         @(negedge CLK_IN);
         if (busy_o) nbusy++;
         if (done_o) ndone++;
      end
      compared++;
      if (nbusy !== 0 || ndone !== 0 || count_o !== 16'd10) begin
         mismatched++;
         $display("FAIL abort_hold: got busy=%0d done=%0d cnt=%0d, need 0 0 10",
                  nbusy, ndone, count_o);
      end
      start_meas(0, 1'b0);
      nbusy = 0;
      repeat (5) begin
         if (busy_o) nbusy++;
         @(negedge CLK_IN);
      end
      gate_len_i = 24'd100;
      start_i    = 1'b1;
      abort_i    = 1'b1;
      @(negedge CLK_IN);
      start_i = 1'b0;
      abort_i = 1'b0;
      repeat (5) begin
         if (busy_o) nbusy++;
         @(negedge CLK_IN);
      end
      compared++;
      if (nbusy !== 0) begin
         mismatched++;
         $display("FAIL abort_nostart: got %0d busy cycles, need 0", nbusy);
      end
   endtask

   task automatic test_slow_dc();
      int nbusy;
      int ndone;
      int dt;
      sig_per = 0;
      sig_man = 1'b0;
      repeat (5) @(negedge CLK_IN);
      start_meas(100, 1'b0);
      nbusy = 0;
      ndone = 0;
      dt    = -1;
      for (int i = 0; i < 120; i++) begin
         if (cyc == t_acc + 41) sig_man = 1'b1;
         if (cyc == t_acc + 60) begin
            start_i    = 1'b1;
            gate_len_i = 24'd5;
            mode_i     = 1'b1;
         end
         if (cyc == t_acc + 61) start_i = 1'b0;
         if (busy_o) nbusy++;
         if (done_o) begin
            ndone++;
            dt = cyc - t_acc;
         end
         @(negedge CLK_IN);
      end
      compared++;
      if (nbusy !== 102 || ndone !== 1 || dt !== 101) begin
         mismatched++;
         $display("FAIL dc_timing: got busy=%0d done=%0d at +%0d, need 102 1 +101",
                  nbusy, ndone, dt);
      end
      compared++;
      if (count_o !== 16'd1 || busy_o !== 1'b0) begin
         mismatched++;
         $display("FAIL dc_count: got cnt=%0d busy=%b, need 1 0", count_o, busy_o);
      end
      sig_man = 1'b0;
   endtask

   task automatic test_async_reset();
      int nbusy;
      sig_per = 10;
      start_meas(100, 1'b0);
      repeat (20) @(negedge CLK_IN);
      @(posedge CLK_IN);
      #2;
      RST_IN = 1'b1;
      #1;
      compared++;
      if ({busy_o, done_o, count_o, overflow_o, led_o} !== 27'd0 ||
          {busy4, done4, count4, ov4} !== 7'd0) begin
         mismatched++;
         $display("FAIL async_rst: got busy=%b cnt=%0d led=%h busy4=%b cnt4=%0d, need all 0",
                  busy_o, count_o, led_o, busy4, count4);
      end
      @(negedge CLK_IN);
      RST_IN = 1'b0;
      nbusy  = 0;
      repeat (120) begin
         @(negedge CLK_IN);
         if (busy_o || done_o || done4) nbusy++;
      end
      compared++;
      if (nbusy !== 0 || count_o !== 16'd0) begin
         mismatched++;
         $display("FAIL async_after: got busy/done cycles=%0d cnt=%0d, need 0 0",
                  nbusy, count_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_shot();
      test_saturation();
      test_continuous();
      test_abort();
      test_slow_dc();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
